mcu_bus_sync: RTL

- Front-end stage that sits directly upstream of fpga_top_design's ECC/chip-select core.
- Takes the asynchronous SRAM-style MCU bus (active-low CS/WE/OE/LB/UB, 21-bit address, 16-bit data) and moves it into the `clk` domain (25/50 MHz RC oscillator).
- Produces clean, single-transaction read/write requests with a valid/ready handshake.
- Returns read data onto `mcu_fpga_io` under a controlled output enable.
- Detects glitches, protocol violations and write overruns.

---
 rtl/mcu_bus_sync.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mcu_bus_sync.sv
// mcu_bus_sync
// Brings the asynchronous SRAM-style MCU bus into the clk domain and turns it
// into single read/write requests with a valid/ready handshake. Read data is
// driven back to the pads under a registered output enable. Glitches are
// filtered out, and protocol, overrun and timeout errors are kept as sticky
// flags.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   mcu_cs_n/we_n/oe_n         async active-low strobes (synchronised and filtered)
//   mcu_lb_n/ub_n              active-low byte enables (sampled raw)
//   mcu_addr, mcu_din          address and write data from the pads (sampled raw)
//   mcu_dout, mcu_doe          read data and output enable to the pads
//   req_valid/ready            request handshake to the downstream core
//   req_write/addr/wdata/be    request payload, req_be = {ub, lb} active high
//   rd_valid, rd_data          single-cycle read response from downstream
//   err_proto/overrun/timeout  sticky error flags
//   err_clr                    clears all sticky flags (a set in the same cycle wins)
module mcu_bus_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2,
  parameter int ADDR_W        = 21,
  parameter int DATA_W        = 16,
  parameter int RD_TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mcu_cs_n,
  input  logic              mcu_we_n,
  input  logic              mcu_oe_n,
  input  logic              mcu_lb_n,
  input  logic              mcu_ub_n,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [DATA_W-1:0] mcu_din,
  output logic [DATA_W-1:0] mcu_dout,
  output logic              mcu_doe,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [1:0]        req_be,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              err_proto,
  output logic              err_overrun,
  output logic              err_timeout,
  input  logic              err_clr
);

  // One shift chain per strobe: the first SYNC_STAGES bits synchronise, and
  // the oldest FILTER_CYCLES bits (starting at the synchroniser output) form
  // the filter window. The registered filter output then lands exactly
  // SYNC_STAGES + FILTER_CYCLES edges after the input changes.
  localparam int CHAIN_W = SYNC_STAGES + FILTER_CYCLES - 1;
  localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ACT, WR_COMMIT, RD_REQ, RD_WAIT, RD_DRIVE, PROTO_ERR
  } state_t;

  // Level moves only when the whole window agrees; otherwise it holds.
  function automatic logic filt_next(input logic [FILTER_CYCLES-1:0] win,
                                     input logic cur);
    if (&win)  return 1'b1;
    if (~|win) return 1'b0;
    return cur;
  endfunction

  logic [CHAIN_W-1:0] cs_sh_q, we_sh_q, oe_sh_q;
  logic               f_cs_q, f_we_q, f_oe_q;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;
  logic [1:0]         hold_be_q, hold_be_d;
  logic               req_valid_q, req_valid_d;
  logic               req_write_q, req_write_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
  logic [1:0]         req_be_q, req_be_d;
  logic [7:0]         tmr_q, tmr_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               doe_q, doe_d;
  logic               err_proto_q, err_overrun_q, err_timeout_q;
  logic               set_proto, set_overrun, set_timeout;
  logic               req_free, proto;

  // Stage p0: synchroniser and glitch filter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sh_q <= '1;
      we_sh_q <= '1;
      oe_sh_q <= '1;
      f_cs_q  <= 1'b1;
      f_we_q  <= 1'b1;
      f_oe_q  <= 1'b1;
    end else begin
      cs_sh_q <= {cs_sh_q[CHAIN_W-2:0], mcu_cs_n};
      we_sh_q <= {we_sh_q[CHAIN_W-2:0], mcu_we_n};
      oe_sh_q <= {oe_sh_q[CHAIN_W-2:0], mcu_oe_n};
      f_cs_q  <= filt_next(cs_sh_q[CHAIN_W-1:SYNC_STAGES-1], f_cs_q);
      f_we_q  <= filt_next(we_sh_q[CHAIN_W-1:SYNC_STAGES-1], f_we_q);
      f_oe_q  <= filt_next(oe_sh_q[CHAIN_W-1:SYNC_STAGES-1], f_oe_q);
    end
  end

  // Stage p1: transaction FSM, request slot and read return
  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_be_d   = hold_be_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    tmr_d       = tmr_q;
    dout_d      = dout_q;
    set_proto   = 1'b0;
    set_overrun = 1'b0;
    set_timeout = 1'b0;

    // The slot can take a new request on the same edge that retires the old one.
    req_free = !req_valid_q || req_ready;
    if (req_valid_q && req_ready) req_valid_d = 1'b0;

    proto = !f_cs_q && !f_we_q && !f_oe_q;

    if (proto) begin
      state_d   = PROTO_ERR;
      set_proto = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!f_cs_q && !f_we_q && f_oe_q)      state_d = WR_ACT;
          else if (!f_cs_q && !f_oe_q && f_we_q) state_d = RD_REQ;
        end
        WR_ACT: begin
          hold_addr_d = mcu_addr;
          hold_data_d = mcu_din;
          hold_be_d   = {~mcu_ub_n, ~mcu_lb_n};
          if (f_we_q || f_cs_q) state_d = WR_COMMIT;
        end
        WR_COMMIT: begin
          if (req_free) begin
            req_valid_d = 1'b1;
            req_write_d = 1'b1;
            req_addr_d  = hold_addr_q;
            req_wdata_d = hold_data_q;
            req_be_d    = hold_be_q;
          end else begin
            set_overrun = 1'b1;
          end
          state_d = IDLE;
        end
        RD_REQ: begin
          if (req_free) begin
            req_valid_d = 1'b1;
            req_write_d = 1'b0;
            req_addr_d  = mcu_addr;
            req_be_d    = {~mcu_ub_n, ~mcu_lb_n};
            tmr_d       = 8'd0;
            state_d     = RD_WAIT;
          end
        end
        RD_WAIT: begin
          // An aborted read beats a response arriving in the same cycle.
          if (f_oe_q || f_cs_q) begin
            state_d = IDLE;
          end else if (rd_valid) begin
            dout_d  = rd_data;
            state_d = RD_DRIVE;
          end else if (tmr_q == TMO_LAST) begin
            set_timeout = 1'b1;
            dout_d      = '0;
            state_d     = RD_DRIVE;
          end else begin
            tmr_d = tmr_q + 8'd1;
          end
        end
        RD_DRIVE: begin
          if (f_oe_q || f_cs_q) state_d = IDLE;
        end
        PROTO_ERR: begin
          if (f_cs_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Registered enable tracks the state, so the pads are driven only in RD_DRIVE.
    doe_d = (state_d == RD_DRIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_valid_q   <= 1'b0;
      req_write_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_be_q      <= '0;
      tmr_q         <= '0;
      dout_q        <= '0;
      doe_q         <= 1'b0;
      err_proto_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_valid_q   <= req_valid_d;
      req_write_q   <= req_write_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      req_be_q      <= req_be_d;
      tmr_q         <= tmr_d;
      dout_q        <= dout_d;
      doe_q         <= doe_d;
      err_proto_q   <= set_proto   | (err_proto_q   & ~err_clr);
      err_overrun_q <= set_overrun | (err_overrun_q & ~err_clr);
      err_timeout_q <= set_timeout | (err_timeout_q & ~err_clr);
    end
  end

  // Write hold registers carry only data and need no reset.
  always_ff @(posedge clk) begin
    hold_addr_q <= hold_addr_d;
    hold_data_q <= hold_data_d;
    hold_be_q   <= hold_be_d;
  end

  // Stage p2: outputs
  assign mcu_dout    = dout_q;
  assign mcu_doe     = doe_q;
  assign req_valid   = req_valid_q;
  assign req_write   = req_write_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;
  assign req_be      = req_be_q;
  assign err_proto   = err_proto_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;

endmodule
